// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder: one shared digit stage walks the operands LSD first,
// one digit per clock, with the inter-digit carry held in a register.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    input  logic                  i_cin,
    output logic [4*DIGITS-1:0]   o_sum,
    output logic                  o_cout,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_invalid
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t              r_state;
    logic [4*DIGITS-1:0] r_a, r_b, r_sum;
    logic [IW-1:0]       r_idx;
    logic                r_c, r_cout, r_busy, r_done, r_invalid;

    logic [3:0] w_ad, w_bd, w_dig;
    logic [4:0] w_t, w_tm;
    logic       w_gt9, w_in_bad;

    // Raw digit sum; anything above 9 (including non-BCD digits) wraps by -10.
    assign w_ad  = r_a[4*r_idx +: 4];
    assign w_bd  = r_b[4*r_idx +: 4];
    assign w_t   = {1'b0, w_ad} + {1'b0, w_bd} + {4'd0, r_c};
    assign w_tm  = w_t - 5'd10;
    assign w_gt9 = (w_t > 5'd9);
    assign w_dig = w_gt9 ? w_tm[3:0] : w_t[3:0];

    always_comb begin
        w_in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i_a[4*i +: 4] > 4'd9 || i_b[4*i +: 4] > 4'd9) w_in_bad = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_c       <= 1'b0;
            r_cout    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a       <= i_a;
                        r_b       <= i_b;
                        r_sum     <= '0;
                        r_idx     <= '0;
                        r_c       <= i_cin;
                        r_cout    <= 1'b0;
                        r_invalid <= w_in_bad;
                        r_busy    <= 1'b1;
                        r_state   <= S_ADD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_sum[4*r_idx +: 4] <= w_dig;
                    r_c                 <= w_gt9;
                    r_idx               <= r_idx + 1'b1;
                    if (r_idx == IW'(DIGITS-1)) begin
                        r_cout  <= w_gt9;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_sum     = r_sum;
    assign o_cout    = r_cout;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_invalid = r_invalid;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4) with a digit-rule reference model.
module tb_bcd_serial_adder;
    localparam int D = 4;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_start = 1'b0;
    logic [4*D-1:0] i_a = '0, i_b = '0;
    logic           i_cin = 1'b0;
    logic [4*D-1:0] o_sum;
    logic           o_cout, o_busy, o_done, o_invalid;

    int n_chk = 0;
    int n_err = 0;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_a(i_a), .i_b(i_b),
        .i_cin(i_cin), .o_sum(o_sum), .o_cout(o_cout), .o_busy(o_busy),
        .o_done(o_done), .o_invalid(o_invalid)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {cout, sum}; non-BCD digits follow the same >9 wrap rule.
    function automatic logic [4*D:0] model(input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                                           input logic cin);
        logic [4*D-1:0] s;
        logic           c;
        int             t;
        s = '0;
        c = cin;
        for (int i = 0; i < D; i++) begin
            t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + int'(c);
            if (t > 9) begin
                t = t - 10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = t[3:0];
        end
        return {c, s};
    endfunction

    function automatic logic bad(input logic [4*D-1:0] a, input logic [4*D-1:0] b);
        logic r;
        r = 1'b0;
        for (int i = 0; i < D; i++) r = r | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
        return r;
    endfunction

    // Wait (bounded) for Done, counting cycles where Busy is seen; caller is at a negedge.
    task automatic wait_done(input string tag, output int nbusy);
        int n;
        n = 0;
        nbusy = 0;
        while (!o_done && n < 20) begin
            if (o_busy) nbusy++;
            n++;
            @(negedge i_clk);
        end
        if (!o_done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_add(input string tag, input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                           input logic cin);
        logic [4*D:0] m;
        int           nb;
        m = model(a, b, cin);
        @(negedge i_clk);
        i_a = a; i_b = b; i_cin = cin; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        chk({tag, "_inv"}, 32'(o_invalid), 32'(bad(a, b)));
        wait_done(tag, nb);
        chk({tag, "_busycyc"}, 32'(nb), 32'(D));
        chk({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
        chk({tag, "_sum"}, 32'(o_sum), 32'(m[4*D-1:0]));
        chk({tag, "_cout"}, 32'(o_cout), 32'(m[4*D]));
        @(negedge i_clk);
        chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        logic [4*D:0] m;
        logic [4*D-1:0] held;
        int nb;

        repeat (2) @(negedge i_clk);
        chk("rst_outs", {14'd0, o_sum, o_cout, o_busy, o_done, o_invalid}, 32'd0);
        i_rst = 1'b0;

        run_add("basic",   16'h1234, 16'h5678, 1'b0);
        chk("basic_const", 32'(o_sum), 32'h6912);
        run_add("ripple",  16'h9999, 16'h0001, 1'b0);
        run_add("cin",     16'h0000, 16'h0000, 1'b1);
        run_add("max",     16'h9999, 16'h9999, 1'b1);
        chk("max_const", {15'd0, o_cout, o_sum}, 32'h19999);
        run_add("invalid", 16'h00F0, 16'h00F0, 1'b0);
        run_add("ff1",     16'h000F, 16'h000F, 1'b1);
        run_add("mixed",   16'h4567, 16'h5555, 1'b0);

        held = o_sum;
        repeat (3) @(negedge i_clk);
        chk("idle_hold_sum", 32'(o_sum), 32'(held));
        chk("idle_hold_inv", 32'(o_invalid), 32'(bad(16'h4567, 16'h5555)));

        // Start and operands change mid-ADD; Start stays high into DONE.
        i_a = 16'h2468; i_b = 16'h1357; i_cin = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_a = 16'h0F00; i_b = 16'h0777; i_cin = 1'b1;
        wait_done("ign", nb);
        m = model(16'h2468, 16'h1357, 1'b0);
        chk("ign_sum", 32'(o_sum), 32'(m[4*D-1:0]));
        chk("ign_cout", 32'(o_cout), 32'(m[4*D]));
        chk("ign_inv", 32'(o_invalid), 32'd0);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("b2b_busy", 32'(o_busy), 32'd1);
        chk("b2b_done_low", 32'(o_done), 32'd0);
        chk("b2b_inv", 32'(o_invalid), 32'd1);
        wait_done("b2b", nb);
        chk("b2b_busycyc", 32'(nb), 32'(D));
        m = model(16'h0F00, 16'h0777, 1'b1);
        chk("b2b_sum", 32'(o_sum), 32'(m[4*D-1:0]));
        chk("b2b_cout", 32'(o_cout), 32'(m[4*D]));

        // Reset during the second ADD cycle, with a carry pending and Invalid set.
        @(negedge i_clk);
        i_a = 16'h09F9; i_b = 16'h0009; i_cin = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("midrst_outs", {14'd0, o_sum, o_cout, o_busy, o_done, o_invalid}, 32'd0);
        @(negedge i_clk);
        chk("midrst_idle", {30'd0, o_busy, o_done}, 32'd0);
        run_add("postrst", 16'h0000, 16'h0000, 1'b0);
        run_add("postrst2", 16'h0109, 16'h0002, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    always @(negedge i_clk) begin
        if (o_busy && o_done) begin
            n_chk++;
            n_err++;
            $display("FAIL busy_done_overlap: got 1 expected 0");
        end
    end
endmodule
